// File: rtl/busca_instrucao.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | busca_instrucao: instruction fetch with kernel/user modes, base offset,   |
// | region check and quantum preemption (counter under BUSCA_QUANTUM_EN).     |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module busca_instrucao #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned ROTINA_BASE = 0,
  parameter int unsigned SO_BASE     = 200,
  parameter int unsigned REGION_SIZE = 200,
  parameter int unsigned QUANTUM     = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  desvio,
  input  logic [ADDR_WIDTH-1:0] alvo_desvio,
  input  logic                  iniciar_usuario,
  input  logic [ADDR_WIDTH-1:0] base_usuario,
  input  logic [ADDR_WIDTH-1:0] pc_usuario,
  input  logic                  fim_programa,
  output logic [ADDR_WIDTH-1:0] endereco,
  output logic                  modo_usuario,
  output logic                  troca_contexto,
  output logic [1:0]            motivo,
  output logic [ADDR_WIDTH-1:0] pc_salvo
);

  localparam logic [ADDR_WIDTH-1:0] C_ROTINA = ADDR_WIDTH'(ROTINA_BASE);
  localparam logic [ADDR_WIDTH-1:0] C_SO     = ADDR_WIDTH'(SO_BASE);
  localparam logic [ADDR_WIDTH-1:0] C_REGION = ADDR_WIDTH'(REGION_SIZE);
  localparam logic [1:0] C_MOT_NONE    = 2'b00;
  localparam logic [1:0] C_MOT_QUANTUM = 2'b01;
  localparam logic [1:0] C_MOT_FIM     = 2'b10;
  localparam logic [1:0] C_MOT_FAULT   = 2'b11;

  typedef enum logic [1:0] {
    ST_KERNEL = 2'd0,
    ST_USER   = 2'd1,
    ST_TRAP   = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] end_q, end_d;
  logic [ADDR_WIDTH-1:0] salvo_q, salvo_d;
  logic [1:0]            motivo_q, motivo_d;
  logic                  troca_q, troca_d;

  logic [ADDR_WIDTH-1:0] w_pc_next;
  logic                  w_fault;
  logic                  w_quantum_exp;
  logic                  w_trap;
  logic [1:0]            w_causa;
  logic                  w_start;
  logic                  w_user_adv;

  assign w_pc_next  = desvio ? alvo_desvio : (pc_q + ADDR_WIDTH'(1));
  assign w_fault    = (w_pc_next >= C_REGION);
  assign w_trap     = fim_programa | w_fault | w_quantum_exp;
  assign w_causa    = fim_programa ? C_MOT_FIM :
                      w_fault      ? C_MOT_FAULT : C_MOT_QUANTUM;
  assign w_start    = !stall && (state_q == ST_KERNEL) && iniciar_usuario;
  assign w_user_adv = !stall && (state_q == ST_USER);

`ifdef BUSCA_QUANTUM_EN
  localparam int unsigned CW = (QUANTUM > 0) ? $clog2(QUANTUM + 1) : 1;
  logic [CW-1:0] cnt_q, cnt_d;

  // Trap on the cycle whose decrement lands on zero (or when already drained).
  assign w_quantum_exp = (cnt_q <= CW'(1));

  always_comb begin
    cnt_d = cnt_q;
    if (w_start) begin
      cnt_d = CW'(QUANTUM);
    end else if (w_user_adv && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  wire w_unused_quantum = (QUANTUM != 0) & w_user_adv;
  assign w_quantum_exp = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    base_d   = base_q;
    end_d    = end_q;
    salvo_d  = salvo_q;
    motivo_d = motivo_q;
    troca_d  = troca_q;
    if (!stall) begin
      case (state_q)
        ST_KERNEL: begin
          if (iniciar_usuario) begin
            state_d = ST_USER;
            base_d  = base_usuario;
            pc_d    = pc_usuario;
            end_d   = base_usuario + pc_usuario;
          end else begin
            pc_d  = w_pc_next;
            end_d = w_pc_next;
          end
        end
        ST_USER: begin
          if (w_trap) begin
            // The branch is not taken on a trap; its target only becomes pc_salvo.
            state_d  = ST_TRAP;
            salvo_d  = w_pc_next;
            motivo_d = w_causa;
            troca_d  = 1'b1;
            pc_d     = C_ROTINA;
          end else begin
            pc_d  = w_pc_next;
            end_d = base_q + w_pc_next;
          end
        end
        ST_TRAP: begin
          state_d = ST_KERNEL;
          troca_d = 1'b0;
          end_d   = pc_q;
        end
        default: begin
          state_d = ST_KERNEL;
          troca_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_KERNEL;
      pc_q     <= C_SO;
      base_q   <= '0;
      end_q    <= C_SO;
      salvo_q  <= '0;
      motivo_q <= C_MOT_NONE;
      troca_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      base_q   <= base_d;
      end_q    <= end_d;
      salvo_q  <= salvo_d;
      motivo_q <= motivo_d;
      troca_q  <= troca_d;
    end
  end

  assign endereco       = end_q;
  assign modo_usuario   = (state_q == ST_USER);
  assign troca_contexto = troca_q;
  assign motivo         = motivo_q;
  assign pc_salvo       = salvo_q;

endmodule
`default_nettype wire

// File: doc/busca_instrucao.md
# busca_instrucao

Instruction-fetch unit that sits directly upstream of the instruction RAM and drives its `endereco` input. It owns the program counter and tracks kernel mode versus user-program mode. In user mode it adds the running program's base address in instruction memory to the PC. It preempts the user program after a fixed quantum, redirects fetch to the context-switch routine, and exports the interrupted PC for the OS to save.

## Interface
Parameters:
- ADDR_WIDTH, 32, width of PC, base and `endereco`
- ROTINA_BASE, 0, absolute address of the context-switch routine
- SO_BASE, 200, absolute address where fetch starts after reset
- REGION_SIZE, 200, words per user-program region (relative PC limit)
- QUANTUM, 64, user fetches allowed before preemption

Ports:
- clock  in  1  single system clock, rising edge
- reset  in  1  asynchronous, active-high
- stall  in  1  hold all state; no fetch advance
- desvio  in  1  taken branch or jump this cycle
- alvo_desvio  in  ADDR_WIDTH  branch target; absolute in kernel mode, relative in user mode
- iniciar_usuario  in  1  kernel request to enter user mode
- base_usuario  in  ADDR_WIDTH  region base of the program being started (400, 600, ...)
- pc_usuario  in  ADDR_WIDTH  relative PC to resume at
- fim_programa  in  1  user program executed its halt instruction
- endereco  out  ADDR_WIDTH  registered absolute fetch address to instruction RAM
- modo_usuario  out  1  1 while in USER state
- troca_contexto  out  1  one-cycle pulse when a trap is taken
- motivo  out  2  trap cause: 00 none, 01 quantum, 10 fim_programa, 11 region fault
- pc_salvo  out  ADDR_WIDTH  relative PC of the next unexecuted user instruction at trap

## Operation
- States: KERNEL, USER, TRAP.
- Priority each cycle, highest first: reset > stall > trap condition (USER only) > desvio > increment.
- KERNEL:
  - Without desvio, pc advances by 1.
  - With desvio, pc = alvo_desvio.
  - `endereco` = pc.
  - iniciar_usuario takes priority over desvio. It sets base = base_usuario, pc = pc_usuario, quantum counter = QUANTUM, and moves to USER.
- USER:
  - `endereco` = base + pc, modulo 2^ADDR_WIDTH.
  - Without desvio, pc advances by 1. With desvio, pc = alvo_desvio (relative).
  - Each non-stalled cycle decrements the quantum counter.
  - The counter width is the minimum that holds QUANTUM and saturates at 0.
- Trap conditions in USER state:
  - fim_programa → motivo 10.
  - Next relative pc ≥ REGION_SIZE → motivo 11.
  - Quantum counter reaches 0 → motivo 01.
  - If several fire in the same cycle, the priority is 10 > 11 > 01.
- TRAP (exactly one cycle):
  - pc_salvo = relative pc that would have been fetched next, i.e. the desvio target or pc+1.
  - motivo latched; troca_contexto = 1.
  - pc = ROTINA_BASE; next state KERNEL, so `endereco` = ROTINA_BASE on the following cycle.
- Region fault is checked against the relative pc before base is added. alvo_desvio ≥ REGION_SIZE also faults.
- motivo and pc_salvo hold their values until the next trap.
- Kernel mode has no limit check.

## Timing
- Reset, asynchronous, active-high:
  - State is KERNEL and pc is SO_BASE.
  - `endereco` = SO_BASE, modo_usuario = 0, troca_contexto = 0, motivo = 00, pc_salvo = 0.
  - Quantum counter = 0 and base = 0.
- `endereco` is registered: a decision made in cycle n appears in cycle n+1. The RAM returns the instruction one edge later, so fetch-to-instruction latency is 2 edges.
- Stall:
  - Freezes pc, state, counter and `endereco`.
  - A stall in TRAP delays the trap, and troca_contexto stays high until the first non-stalled cycle.
- iniciar_usuario while in USER or TRAP is ignored.
- desvio in the same cycle as a trap is folded into pc_salvo; the branch itself is not taken.
- Reset mid-trap aborts the trap with no pulse.

## Configuration
- BUSCA_QUANTUM_EN defined:
  - Quantum counter and motivo 01 are compiled in.
- BUSCA_QUANTUM_EN undefined:
  - No counter is built.
  - USER runs until fim_programa or region fault.
  - motivo 01 is never produced.
  - QUANTUM is ignored.

## Test plan
- Reset release, no stimulus → `endereco` 200, 201, 202 on successive edges; modo_usuario = 0.
- Kernel desvio to 0 → `endereco` = 0 on the next edge, then 1.
- iniciar_usuario with base 400 and pc 5 → `endereco` 405, 406, ...; modo_usuario = 1.
- With QUANTUM = 4, start user at base 600 and pc 0:
  - Expect fetches 600–603.
  - Then the trap: troca_contexto pulse, motivo 01, pc_salvo 4.
  - Then `endereco` 0.
- User desvio to 199 followed by increment → fault; expect motivo 11, pc_salvo 200.
- fim_programa, quantum expiry and stall all in the same cycle:
  - No trap while stall is held.
  - On release, expect motivo 10.
